// File: rtl/dcache_controller.sv
// Direct-mapped write-back data cache controller: tag/valid/dirty/data arrays
// plus the miss-handling FSM (write-back, block fill, array update).
module dcache_controller #(
  parameter int TAG_W   = 3,
  parameter int INDEX_W = 3,
  parameter int ADDR_W  = TAG_W + INDEX_W + 2
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     read,
  input  logic                     write,
  input  logic [ADDR_W-1:0]        address,
  input  logic [7:0]               writedata,
  output logic [7:0]               readdata,
  output logic                     busywait,
  output logic [TAG_W-1:0]         current_tag,
  output logic [TAG_W-1:0]         stored_tag,
  input  logic                     tag_match,
  output logic                     mem_read,
  output logic                     mem_write,
  output logic [TAG_W+INDEX_W-1:0] mem_address,
  output logic [31:0]              mem_writedata,
  input  logic [31:0]              mem_readdata,
  input  logic                     mem_busywait
);

  localparam int BLOCKS = 2 ** INDEX_W;

  typedef enum logic [1:0] {
    IDLE,
    MEM_READ,
    MEM_WRITE,
    UPDATE
  } state_t;

  state_t state, next_state;

  logic [31:0]      data_array [BLOCKS];
  logic [TAG_W-1:0] tag_array  [BLOCKS];
  logic [BLOCKS-1:0] valid;
  logic [BLOCKS-1:0] dirty;
  logic [31:0]      fill;

  logic [INDEX_W-1:0] index;
  logic [1:0]         offset;
  logic [4:0]         bit_base;
  logic               hit;
  logic               request;
  logic               write_hit;

  assign current_tag = address[ADDR_W-1:INDEX_W+2];
  assign index       = address[INDEX_W+1:2];
  assign offset      = address[1:0];
  assign bit_base    = {offset, 3'b000};
  assign stored_tag  = tag_array[index];

  assign hit       = valid[index] & tag_match;
  assign request   = read | write;
  assign write_hit = (state == IDLE) & write & hit;

  // Stall is forced low while reset is held so an aborted miss releases the CPU at once.
  assign busywait = reset & request & ~((state == IDLE) & hit);
  assign readdata = ((state == IDLE) & read & ~write & hit)
                    ? data_array[index][bit_base +: 8] : '0;

  always_comb begin
    next_state    = state;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    mem_address   = '0;
    mem_writedata = '0;
    unique case (state)
      IDLE: begin
        if (request && !hit)
          next_state = dirty[index] ? MEM_WRITE : MEM_READ;
      end
      MEM_WRITE: begin
        mem_write     = 1'b1;
        mem_address   = {stored_tag, index};
        mem_writedata = data_array[index];
        if (!mem_busywait)
          next_state = MEM_READ;
      end
      MEM_READ: begin
        mem_read    = 1'b1;
        mem_address = {current_tag, index};
        if (!mem_busywait)
          next_state = UPDATE;
      end
      UPDATE: begin
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      valid <= '0;
      dirty <= '0;
      fill  <= '0;
    end else begin
      state <= next_state;
      if (state == MEM_READ && !mem_busywait)
        fill <= mem_readdata;
      if (state == UPDATE) begin
        valid[index] <= 1'b1;
        dirty[index] <= 1'b0;
      end else if (write_hit) begin
        dirty[index] <= 1'b1;
      end
    end
  end

  // Data and tags are deliberately left uncleared; valid bits gate every use.
  always_ff @(posedge clock) begin
    if (state == UPDATE) begin
      data_array[index] <= fill;
      tag_array[index]  <= current_tag;
    end else if (write_hit) begin
      data_array[index][bit_base +: 8] <= writedata;
    end
  end

endmodule

// File: tb/tb_dcache_controller.sv
// Directed bench for dcache_controller: cold fill, write hit, dirty eviction,
// memory stall, reset mid-miss and request dropped mid-miss.
module tb_dcache_controller;

  logic        clock;
  logic        reset;
  logic        read;
  logic        write;
  logic [7:0]  address;
  logic [7:0]  writedata;
  logic [7:0]  readdata;
  logic        busywait;
  logic [2:0]  current_tag;
  logic [2:0]  stored_tag;
  logic        tag_match;
  logic        mem_read;
  logic        mem_write;
  logic [5:0]  mem_address;
  logic [31:0] mem_writedata;
  logic [31:0] mem_readdata;
  logic        mem_busywait;

  int checks = 0;
  int errors = 0;

  dcache_controller #(.TAG_W(3), .INDEX_W(3)) dut (
    .clock         (clock),
    .reset         (reset),
    .read          (read),
    .write         (write),
    .address       (address),
    .writedata     (writedata),
    .readdata      (readdata),
    .busywait      (busywait),
    .current_tag   (current_tag),
    .stored_tag    (stored_tag),
    .tag_match     (tag_match),
    .mem_read      (mem_read),
    .mem_write     (mem_write),
    .mem_address   (mem_address),
    .mem_writedata (mem_writedata),
    .mem_readdata  (mem_readdata),
    .mem_busywait  (mem_busywait)
  );

  // Tag comparator lives outside the cache.
  assign tag_match = (current_tag == stored_tag);

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    reset        = 1'b0;
    read         = 1'b0;
    write        = 1'b0;
    address      = '0;
    writedata    = '0;
    mem_readdata = '0;
    mem_busywait = 1'b1;
    tick();
    tick();
    chk("rst_readdata",  {24'h0, readdata}, 32'h0);
    chk("rst_busywait",  {31'h0, busywait}, 32'h0);
    chk("rst_mem_read",  {31'h0, mem_read}, 32'h0);
    chk("rst_mem_write", {31'h0, mem_write}, 32'h0);
    chk("rst_mem_addr",  {26'h0, mem_address}, 32'h0);
    chk("rst_mem_wdata", mem_writedata, 32'h0);
    reset = 1'b1;
    tick();

    // 1: cold read of 0x2D (tag 1, index 3, offset 1)
    read = 1'b1; address = 8'h2D;
    #1;
    chk("s1_busy_idle", {31'h0, busywait}, 32'h1);
    chk("s1_no_memrd_idle", {31'h0, mem_read}, 32'h0);
    tick();
    chk("s1_mem_read", {31'h0, mem_read}, 32'h1);
    chk("s1_mem_addr", {26'h0, mem_address}, 32'h0B);
    chk("s1_busy_mr", {31'h0, busywait}, 32'h1);
    mem_busywait = 1'b0; mem_readdata = 32'hAABBCCDD;
    tick();
    chk("s1_update_memrd", {31'h0, mem_read}, 32'h0);
    chk("s1_update_busy", {31'h0, busywait}, 32'h1);
    mem_busywait = 1'b1;
    tick();
    chk("s1_hit_busy", {31'h0, busywait}, 32'h0);
    chk("s1_readdata", {24'h0, readdata}, 32'hCC);

    // 2: write hit at 0x2E
    read = 1'b0; write = 1'b1; address = 8'h2E; writedata = 8'h55;
    #1;
    chk("s2_wr_busy", {31'h0, busywait}, 32'h0);
    tick();
    write = 1'b0; read = 1'b1;
    #1;
    chk("s2_readback", {24'h0, readdata}, 32'h55);
    chk("s2_rd_busy", {31'h0, busywait}, 32'h0);

    // 3+4: dirty conflict miss at 0x4C with stalled memory
    address = 8'h4C;
    #1;
    chk("s3_busy", {31'h0, busywait}, 32'h1);
    tick();
    chk("s3_mem_write", {31'h0, mem_write}, 32'h1);
    chk("s3_wb_no_rd", {31'h0, mem_read}, 32'h0);
    chk("s3_wb_addr", {26'h0, mem_address}, 32'h0B);
    chk("s3_wb_data", mem_writedata, 32'hAA55CCDD);
    tick();
    chk("s3_wb_hold", {31'h0, mem_write}, 32'h1);
    mem_busywait = 1'b0;
    tick();
    mem_busywait = 1'b1;
    chk("s3_mr_read", {31'h0, mem_read}, 32'h1);
    chk("s3_mr_no_wr", {31'h0, mem_write}, 32'h0);
    chk("s3_mr_addr", {26'h0, mem_address}, 32'h13);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("s4_stall_read", {31'h0, mem_read}, 32'h1);
      chk("s4_stall_addr", {26'h0, mem_address}, 32'h13);
      chk("s4_stall_busy", {31'h0, busywait}, 32'h1);
    end
    mem_busywait = 1'b0; mem_readdata = 32'h11223344;
    tick();
    chk("s4_exit_read", {31'h0, mem_read}, 32'h0);
    mem_busywait = 1'b1;
    tick();
    chk("s3_hit_busy", {31'h0, busywait}, 32'h0);
    chk("s3_readdata", {24'h0, readdata}, 32'h44);

    // Old block (tag 1) now misses clean: no write-back expected
    address = 8'h2D;
    #1;
    chk("s3_old_miss", {31'h0, busywait}, 32'h1);
    tick();
    chk("s3_clean_no_wr", {31'h0, mem_write}, 32'h0);
    chk("s3_clean_rd", {31'h0, mem_read}, 32'h1);
    chk("s3_clean_addr", {26'h0, mem_address}, 32'h0B);

    // 5: reset mid-miss
    reset = 1'b0;
    #1;
    chk("s5_rst_memrd", {31'h0, mem_read}, 32'h0);
    chk("s5_rst_busy", {31'h0, busywait}, 32'h0);
    tick();
    reset = 1'b1;
    address = 8'h4C;
    #1;
    chk("s5_valid_clr", {31'h0, busywait}, 32'h1);
    tick();
    chk("s5_miss_rd", {31'h0, mem_read}, 32'h1);
    chk("s5_miss_no_wr", {31'h0, mem_write}, 32'h0);
    mem_busywait = 1'b0; mem_readdata = 32'h55667788;
    tick();
    mem_busywait = 1'b1;
    tick();
    chk("s5_readdata", {24'h0, readdata}, 32'h88);

    // 6: write miss at 0x80, request dropped during MEM_READ
    read = 1'b0; write = 1'b1; address = 8'h80; writedata = 8'hEE;
    tick();
    chk("s6_mr_read", {31'h0, mem_read}, 32'h1);
    chk("s6_mr_addr", {26'h0, mem_address}, 32'h20);
    write = 1'b0;
    mem_busywait = 1'b0; mem_readdata = 32'h99887766;
    tick();
    mem_busywait = 1'b1;
    tick();
    read = 1'b1;
    #1;
    chk("s6_hit_busy", {31'h0, busywait}, 32'h0);
    chk("s6_byte0", {24'h0, readdata}, 32'h66);
    address = 8'h83;
    #1;
    chk("s6_byte3", {24'h0, readdata}, 32'h99);
    address = 8'hA0;
    tick();
    chk("s6_clean_no_wr", {31'h0, mem_write}, 32'h0);
    chk("s6_clean_addr", {26'h0, mem_address}, 32'h28);
    read = 1'b0;
    mem_busywait = 1'b0; mem_readdata = 32'h0;
    tick();
    tick();
    chk("s6_idle_busy", {31'h0, busywait}, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
